// File: rtl/uart_rx_fifo.sv
// UART receiver: two-flop synchroniser, mid-bit sampling FSM with optional parity,
// and a first-word-fall-through FIFO that buffers {perr, data} entries.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       din,
    output logic [7:0] dout,
    output logic       dout_perr,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [AW:0]      DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   din_meta_q, din_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   push, pop, full, wr_en;
    logic [DATA_BITS:0]     mem [FIFO_DEPTH];
    logic [DATA_BITS:0]     head;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_meta_q  <= 1'b1;
            din_s_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            perr_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            din_meta_q  <= din;
            din_s_q     <= din_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            perr_q      <= perr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {perr_q, shift_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_en && !din_s_q) begin
                    state_d = S_START;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = din_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = din_s_q;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    // Odd mode expects an odd total of ones; even mode an even total.
                    perr_d  = (PARITY == 1) ? ~(^shift_q ^ din_s_q) : (^shift_q ^ din_s_q);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (din_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (din_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        full      = (count_q == DEPTH);
        pop       = (count_q != '0) && dout_ready;
        // A full FIFO still accepts a push when the head is popped in the same cycle.
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        head       = mem[rd_ptr_q];
        dout_valid = (count_q != '0);
        dout       = '0;
        dout_perr  = 1'b0;
        if (dout_valid) begin
            dout[DATA_BITS-1:0] = head[DATA_BITS-1:0];
            dout_perr           = head[DATA_BITS];
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 receiver (A) and a 7-bit even-parity receiver (B) share one clock.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       din_a = 1'b1, din_b = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       perr_a, perr_b, valid_a, valid_b;
    logic       fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fe_cnt = 0, fe_cyc = -1, ov_cnt = 0, ov_cyc = -1, vrise_cyc = -1;
    logic vprev = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .rx_en(rx_en), .din(din_a),
        .dout(dout_a), .dout_perr(perr_a), .dout_valid(valid_a), .dout_ready(ready_a),
        .frame_err(fe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .rx_en(rx_en), .din(din_b),
        .dout(dout_b), .dout_perr(perr_b), .dout_valid(valid_b), .dout_ready(ready_b),
        .frame_err(fe_b), .overrun(ov_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fe_a) begin fe_cnt++; fe_cyc = cyc; end
        if (ov_a) begin ov_cnt++; ov_cyc = cyc; end
        if (valid_a && !vprev) vrise_cyc = cyc;
        vprev = valid_a;
    end

    typedef struct {
        bit         sel;
        logic [7:0] data;
        bit         bad_par;
        logic [7:0] exp_dout;
        logic       exp_perr;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) din_b = v; else din_a = v;
    endtask

    // Frame for A: 8 data bits, no parity. For B: 7 data bits plus even parity (optionally wrong).
    task automatic send(input bit sel, input logic [7:0] data, input bit bad_par, input logic stop);
        int nbits;
        logic [7:0] d;
        d = data;
        nbits = sel ? 7 : 8;
        start_cyc = cyc;
        drive(sel, 1'b0); tick(16);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, d[i]); tick(16);
        end
        if (sel) begin
            drive(sel, (^d[6:0]) ^ bad_par); tick(16);
        end
        drive(sel, stop); tick(16);
        drive(sel, 1'b1);
    endtask

    task automatic pop(input bit sel);
        if (sel) ready_b = 1'b1; else ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        int fe0, ov0;
        logic [7:0] exp_q [4];

        vecs[0] = '{0, 8'h00, 0, 8'h00, 0};
        vecs[1] = '{0, 8'hFF, 0, 8'hFF, 0};
        vecs[2] = '{0, 8'h81, 0, 8'h81, 0};
        vecs[3] = '{1, 8'h41, 0, 8'h41, 0};
        vecs[4] = '{1, 8'h41, 1, 8'h41, 1};
        vecs[5] = '{1, 8'h7F, 1, 8'h7F, 1};
        vecs[6] = '{1, 8'h2A, 0, 8'h2A, 0};
        vecs[7] = '{1, 8'hC3, 0, 8'h43, 0};

        tick(3);
        rst = 1'b0;
        check("reset dout", {24'd0, dout_a}, 32'h0);
        check("reset flags", {26'd0, perr_a, valid_a, fe_a, ov_a, busy_a, valid_b}, 32'h0);
        tick(4);

        // 0xA5 latency and hold
        send(0, 8'hA5, 0, 1'b1);
        check("a5 valid rise cycle", vrise_cyc - start_cyc, 32'd155);
        check("a5 dout", {24'd0, dout_a}, 32'hA5);
        check("a5 perr", {31'd0, perr_a}, 32'h0);
        tick(30);
        check("a5 held", {23'd0, valid_a, dout_a}, 32'h1A5);
        pop(0);
        check("a5 popped", {31'd0, valid_a}, 32'h0);

        // table of single frames
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].sel, vecs[i].data, vecs[i].bad_par, 1'b1);
            tick(2);
            if (vecs[i].sel) begin
                check($sformatf("vec%0d dout", i), {24'd0, dout_b}, {24'd0, vecs[i].exp_dout});
                check($sformatf("vec%0d perr", i), {31'd0, perr_b}, {31'd0, vecs[i].exp_perr});
            end else begin
                check($sformatf("vec%0d dout", i), {24'd0, dout_a}, {24'd0, vecs[i].exp_dout});
                check($sformatf("vec%0d perr", i), {31'd0, perr_a}, {31'd0, vecs[i].exp_perr});
            end
            pop(vecs[i].sel);
            check($sformatf("vec%0d empty", i), {30'd0, valid_a, valid_b}, 32'h0);
        end

        // parity good then bad, both queued
        send(1, 8'h41, 0, 1'b1);
        send(1, 8'h41, 1, 1'b1);
        check("par first", {23'd0, perr_b, dout_b}, 32'h041);
        pop(1);
        check("par second", {23'd0, perr_b, dout_b}, 32'h141);
        pop(1);
        check("par empty", {31'd0, valid_b}, 32'h0);

        // 5-cycle glitch, then a real frame
        fe0 = fe_cnt;
        din_a = 1'b0; tick(5); din_a = 1'b1; tick(20);
        check("glitch idle", {29'd0, busy_a, valid_a, fe_a}, 32'h0);
        check("glitch no fe", fe_cnt - fe0, 32'd0);
        send(0, 8'h3C, 0, 1'b1);
        check("after glitch dout", {23'd0, valid_a, dout_a}, 32'h13C);
        pop(0);

        // stop bit low, long break
        fe0 = fe_cnt;
        send(0, 8'h55, 0, 1'b0);
        din_a = 1'b0;
        tick(640);
        din_a = 1'b1;
        tick(32);
        check("break fe count", fe_cnt - fe0, 32'd1);
        check("break fe cycle", fe_cyc - start_cyc, 32'd155);
        check("break fifo empty", {30'd0, valid_a, busy_a}, 32'h0);
        send(0, 8'h12, 0, 1'b1);
        check("after break dout", {23'd0, valid_a, dout_a}, 32'h112);
        pop(0);

        // rx_en low blocks start detection
        rx_en = 1'b0;
        send(0, 8'h33, 0, 1'b1);
        tick(5);
        check("rx_en off", {30'd0, valid_a, busy_a}, 32'h0);
        rx_en = 1'b1;

        // overrun on fifth queued frame
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 1'b1);
        tick(2);
        check("overrun count", ov_cnt - ov0, 32'd1);
        check("overrun cycle", ov_cyc - start_cyc, 32'd155);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), {23'd0, valid_a, dout_a}, {23'd0, 1'b1, 8'(i + 1)});
            pop(0);
        end
        check("drain empty", {31'd0, valid_a}, 32'h0);

        // full FIFO, pop exactly on the stop-sample cycle
        ov0 = ov_cnt;
        for (int i = 6; i <= 9; i++) send(0, 8'(i), 0, 1'b1);
        fork
            send(0, 8'hE7, 0, 1'b1);
            begin tick(154); ready_a = 1'b1; tick(1); ready_a = 1'b0; end
        join
        tick(2);
        check("coincide no overrun", ov_cnt - ov0, 32'd0);
        exp_q = '{8'h07, 8'h08, 8'h09, 8'hE7};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("coincide drain%0d", i), {23'd0, valid_a, dout_a}, {23'd0, 1'b1, exp_q[i]});
            pop(0);
        end
        check("coincide empty", {31'd0, valid_a}, 32'h0);

        // reset mid-DATA with an entry queued
        send(0, 8'h5A, 0, 1'b1);
        din_a = 1'b0; tick(16);
        din_a = 1'b1; tick(16);
        din_a = 1'b0; tick(10);
        check("mid data busy", {31'd0, busy_a}, 32'h1);
        rst = 1'b1; din_a = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst dout", {24'd0, dout_a}, 32'h0);
        check("rst flags", {27'd0, perr_a, valid_a, fe_a, ov_a, busy_a}, 32'h0);
        tick(20);
        check("rst stays idle", {30'd0, valid_a, busy_a}, 32'h0);
        send(0, 8'h99, 0, 1'b1);
        check("after rst dout", {23'd0, valid_a, dout_a}, 32'h199);
        pop(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
